// File: rtl/local_ni_pkg.sv
// Shared definitions for the local network interface: flit width, TX/RX state encodings,
// start-bit value and stats counter width. PAYLOAD_SIZE / ADDR_BITS fall back to 8 / 4.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package local_ni_pkg;
  localparam logic START_BIT = 1'b1;
  localparam int   STAT_W    = 16;

  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_SHIFT, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_HOLD} rx_state_t;

  function automatic int flit_w(input int payload_w, input int addr_w);
    return payload_w + addr_w;
  endfunction
endpackage

// File: rtl/ni_deser.sv
// Eject deserializer: start-bit detect, LSB-first shift-in, then holds the flit until the
// core takes it (ej_valid && ej_ready). rx_busy covers the whole frame plus the hold.
module ni_deser
  import local_ni_pkg::*;
#(
  parameter int NODE_ID   = -1,
  parameter int PAYLOAD_W = 8,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data,
  output logic                 rx_busy,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [ADDR_W-1:0]    ej_dest,
  output logic [PAYLOAD_W-1:0] ej_payload,
  output logic                 ej_addr_err
);
  localparam int              FLIT_W    = flit_w(PAYLOAD_W, ADDR_W);
  localparam int              CNT_W     = $clog2(FLIT_W);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FLIT_W - 1);
  // A negative NODE_ID never matches any zero-extended address.
  localparam logic [31:0]     NODE_ID_U = 32'(NODE_ID);

  rx_state_t            state, state_d;
  logic [FLIT_W-1:0]    sh, sh_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 busy_d, valid_d, err_d;
  logic [ADDR_W-1:0]    dest_d;
  logic [PAYLOAD_W-1:0] payload_d;

  always_comb begin
    state_d   = state;
    sh_d      = sh;
    cnt_d     = cnt;
    busy_d    = rx_busy;
    valid_d   = ej_valid;
    dest_d    = ej_dest;
    payload_d = ej_payload;
    err_d     = ej_addr_err;
    case (state)
      RX_IDLE: begin
        if (rx_data == START_BIT) begin
          state_d = RX_SHIFT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RX_SHIFT: begin
        sh_d  = {rx_data, sh[FLIT_W-1:1]};
        cnt_d = cnt + 1'b1;
        if (cnt == LAST) begin
          state_d   = RX_HOLD;
          valid_d   = 1'b1;
          dest_d    = sh_d[ADDR_W-1:0];
          payload_d = sh_d[FLIT_W-1:ADDR_W];
          err_d     = (32'(sh_d[ADDR_W-1:0]) != NODE_ID_U);
        end
      end
      RX_HOLD: begin
        // Line activity here is a protocol violation and is deliberately ignored.
        if (ej_ready) begin
          state_d = RX_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RX_IDLE;
      sh          <= '0;
      cnt         <= '0;
      rx_busy     <= 1'b0;
      ej_valid    <= 1'b0;
      ej_dest     <= '0;
      ej_payload  <= '0;
      ej_addr_err <= 1'b0;
    end else begin
      state       <= state_d;
      sh          <= sh_d;
      cnt         <= cnt_d;
      rx_busy     <= busy_d;
      ej_valid    <= valid_d;
      ej_dest     <= dest_d;
      ej_payload  <= payload_d;
      ej_addr_err <= err_d;
    end
  end
endmodule

// File: rtl/local_ni.sv
// Local network interface: serializes core flits onto the router local rx line and
// deserializes router frames for the core. Optional NI_STATS_EN adds inj/ej counters.
module local_ni
  import local_ni_pkg::*;
#(
  parameter int NODE_ID   = -1,
  parameter int PAYLOAD_W = `PAYLOAD_SIZE,
  parameter int ADDR_W    = `ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [ADDR_W-1:0]    inj_dest,
  input  logic [PAYLOAD_W-1:0] inj_payload,
  output logic                 link_tx_data,
  input  logic                 link_tx_busy,
  input  logic                 link_rx_data,
  output logic                 link_rx_busy,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [ADDR_W-1:0]    ej_dest,
  output logic [PAYLOAD_W-1:0] ej_payload,
  output logic                 ej_addr_err
`ifdef NI_STATS_EN
  ,
  output logic [STAT_W-1:0]    inj_count,
  output logic [STAT_W-1:0]    ej_count
`endif
);
  localparam int               FLIT_W = flit_w(PAYLOAD_W, ADDR_W);
  localparam int               CNT_W  = $clog2(FLIT_W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(FLIT_W - 1);

  tx_state_t         tx_state, tx_state_d;
  logic [FLIT_W-1:0] tx_sh, tx_sh_d;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_d;
  logic              tx_data_d, inj_ready_d;

  always_comb begin
    tx_state_d  = tx_state;
    tx_sh_d     = tx_sh;
    tx_cnt_d    = tx_cnt;
    tx_data_d   = 1'b0;
    inj_ready_d = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        inj_ready_d = 1'b1;
        if (inj_valid) begin
          tx_state_d  = TX_WAIT;
          tx_sh_d     = {inj_payload, inj_dest};
          inj_ready_d = 1'b0;
        end
      end
      // Busy is honoured only before the start bit; a started frame always completes.
      TX_WAIT: begin
        if (!link_tx_busy) begin
          tx_state_d = TX_START;
          tx_data_d  = START_BIT;
        end
      end
      TX_START: begin
        tx_state_d = TX_SHIFT;
        tx_data_d  = tx_sh[0];
        tx_sh_d    = tx_sh >> 1;
        tx_cnt_d   = '0;
      end
      TX_SHIFT: begin
        if (tx_cnt == LAST) begin
          tx_state_d = TX_GAP;
        end else begin
          tx_data_d = tx_sh[0];
          tx_sh_d   = tx_sh >> 1;
          tx_cnt_d  = tx_cnt + 1'b1;
        end
      end
      TX_GAP: begin
        tx_state_d  = TX_IDLE;
        inj_ready_d = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state     <= TX_IDLE;
      tx_sh        <= '0;
      tx_cnt       <= '0;
      link_tx_data <= 1'b0;
      inj_ready    <= 1'b1;
    end else begin
      tx_state     <= tx_state_d;
      tx_sh        <= tx_sh_d;
      tx_cnt       <= tx_cnt_d;
      link_tx_data <= tx_data_d;
      inj_ready    <= inj_ready_d;
    end
  end

  ni_deser #(
    .NODE_ID  (NODE_ID),
    .PAYLOAD_W(PAYLOAD_W),
    .ADDR_W   (ADDR_W)
  ) u_deser (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (link_rx_data),
    .rx_busy    (link_rx_busy),
    .ej_valid   (ej_valid),
    .ej_ready   (ej_ready),
    .ej_dest    (ej_dest),
    .ej_payload (ej_payload),
    .ej_addr_err(ej_addr_err)
  );

`ifdef NI_STATS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inj_count <= '0;
      ej_count  <= '0;
    end else begin
      if (tx_state == TX_WAIT && !link_tx_busy && inj_count != '1)
        inj_count <= inj_count + 1'b1;
      if (ej_valid && ej_ready && ej_count != '1)
        ej_count <= ej_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_local_ni.sv
// Bench for local_ni (PAYLOAD_W=8, ADDR_W=4, NODE_ID=5): frame-timeline reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_local_ni;
  localparam int PW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 12;
  localparam int NID = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          inj_valid, inj_ready;
  logic [AW-1:0] inj_dest;
  logic [PW-1:0] inj_payload;
  logic          link_tx_data, link_tx_busy, link_rx_data, link_rx_busy;
  logic          ej_valid, ej_ready, ej_addr_err;
  logic [AW-1:0] ej_dest;
  logic [PW-1:0] ej_payload;
`ifdef NI_STATS_EN
  logic [15:0]   inj_count, ej_count;
`endif

  local_ni #(.NODE_ID(NID), .PAYLOAD_W(PW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .inj_valid   (inj_valid),
    .inj_ready   (inj_ready),
    .inj_dest    (inj_dest),
    .inj_payload (inj_payload),
    .link_tx_data(link_tx_data),
    .link_tx_busy(link_tx_busy),
    .link_rx_data(link_rx_data),
    .link_rx_busy(link_rx_busy),
    .ej_valid    (ej_valid),
    .ej_ready    (ej_ready),
    .ej_dest     (ej_dest),
    .ej_payload  (ej_payload),
    .ej_addr_err (ej_addr_err)
`ifdef NI_STATS_EN
    ,
    .inj_count   (inj_count),
    .ej_count    (ej_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on a frame timeline: start bit at edge m_start, bit i at m_start+1+i,
  // idle gap at m_start+FW+1, ready again at m_start+FW+2.
  logic          e_inj_ready = 1'b1, e_tx_data = 1'b0;
  logic          e_rx_busy = 1'b0, e_ej_valid = 1'b0, e_err = 1'b0;
  logic [AW-1:0] e_dest = '0;
  logic [PW-1:0] e_payload = '0;
  logic [15:0]   e_inj_cnt = '0, e_ej_cnt = '0;
  bit            m_tx_held = 1'b0, m_rx_hold = 1'b0;
  int            m_start = -1, m_rx_s = -1;
  logic [FW-1:0] m_tx_flit, m_rx_flit;

  always @(posedge clk) begin
    int k;
    cyc++;
    if (!reset) begin
      m_tx_held = 0; m_start = -1; e_tx_data = 0; e_inj_ready = 1;
      m_rx_hold = 0; m_rx_s = -1; e_rx_busy = 0; e_ej_valid = 0;
      e_dest = '0; e_payload = '0; e_err = 0;
      e_inj_cnt = '0; e_ej_cnt = '0;
    end else begin
      if (!m_tx_held) begin
        e_tx_data = 0;
        if (inj_valid) begin
          m_tx_held = 1; m_tx_flit = {inj_payload, inj_dest}; m_start = -1; e_inj_ready = 0;
        end
      end else if (m_start < 0) begin
        e_tx_data = 0;
        if (!link_tx_busy) begin
          m_start = cyc; e_tx_data = 1;
          if (e_inj_cnt != 16'hFFFF) e_inj_cnt++;
        end
      end else begin
        k = cyc - m_start;
        e_tx_data = (k >= 1 && k <= FW) ? m_tx_flit[k-1] : 1'b0;
        if (k == FW + 2) begin m_tx_held = 0; e_inj_ready = 1; end
      end

      if (m_rx_hold) begin
        if (ej_ready) begin
          m_rx_hold = 0; e_ej_valid = 0; e_rx_busy = 0;
          if (e_ej_cnt != 16'hFFFF) e_ej_cnt++;
        end
      end else if (m_rx_s < 0) begin
        if (link_rx_data) begin m_rx_s = cyc; e_rx_busy = 1; m_rx_flit = '0; end
      end else begin
        k = cyc - m_rx_s;
        m_rx_flit[k-1] = link_rx_data;
        if (k == FW) begin
          m_rx_hold = 1; m_rx_s = -1; e_ej_valid = 1;
          e_dest = m_rx_flit[AW-1:0]; e_payload = m_rx_flit[FW-1:AW];
          e_err = ({28'b0, e_dest} != NID);
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_inj_ready", inj_ready, e_inj_ready);
      chk("m_tx_data", link_tx_data, e_tx_data);
      chk("m_rx_busy", link_rx_busy, e_rx_busy);
      chk("m_ej_valid", ej_valid, e_ej_valid);
      if (e_ej_valid) begin
        chk("m_ej_dest", ej_dest, e_dest);
        chk("m_ej_payload", ej_payload, e_payload);
        chk("m_ej_addr_err", ej_addr_err, e_err);
      end
`ifdef NI_STATS_EN
      chk("m_inj_count", inj_count, e_inj_cnt);
      chk("m_ej_count", ej_count, e_ej_cnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic inject(input logic [AW-1:0] d, input logic [PW-1:0] p);
    int n = 0;
    inj_valid = 1; inj_dest = d; inj_payload = p;
    while (!inj_ready && n < 300) begin @(negedge clk); n++; end
    if (!inj_ready) chk("inj_accept_timeout", 0, 1);
    @(negedge clk);
    inj_valid = 0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    @(negedge clk); link_rx_data = 1;
    for (int i = 0; i < FW; i++) begin @(negedge clk); link_rx_data = f[i]; end
    @(negedge clk); link_rx_data = 0;
  endtask

  task automatic ack();
    ej_ready = 1;
    @(negedge clk);
    ej_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [FW-1:0] frame;
    logic          bad;
    inj_valid = 0; inj_dest = '0; inj_payload = '0;
    link_tx_busy = 0; link_rx_data = 0; ej_ready = 0; reset = 0;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("rst_inj_ready", inj_ready, 1);
    chk("rst_tx_data", link_tx_data, 0);
    chk("rst_rx_busy", link_rx_busy, 0);
    chk("rst_ej_valid", ej_valid, 0);
    chk("rst_ej_addr_err", ej_addr_err, 0);
    chk("rst_ej_dest", ej_dest, 0);
    chk("rst_ej_payload", ej_payload, 0);
    reset = 1;
    @(negedge clk);

    // Inject dest=3 payload=A5 with the link free.
    inject(4'd3, 8'hA5);
    @(negedge clk); chk("tx_start_bit", link_tx_data, 1);
    for (int i = 0; i < FW; i++) begin @(negedge clk); frame[i] = link_tx_data; end
    chk("tx_frame_bits", frame, 12'hA53);
    @(negedge clk);
    chk("tx_gap_zero", link_tx_data, 0);
    chk("tx_ready_low_in_gap", inj_ready, 0);
    @(negedge clk); chk("tx_ready_back", inj_ready, 1);

    // Busy held for 20 cycles after accept.
    link_tx_busy = 1;
    inject(4'd9, 8'h3C);
    bad = 0;
    repeat (20) begin @(negedge clk); bad |= link_tx_data | inj_ready; end
    chk("busy_hold_idle", bad, 0);
    link_tx_busy = 0;
    @(negedge clk); chk("busy_release_start", link_tx_data, 1);
    repeat (FW + 3) @(negedge clk);

    // Eject 12'h5C5 with back-pressure and a stray 1 during the hold.
    send_frame(12'h5C5);
    chk("ej_valid_at_s12", ej_valid, 1);
    chk("ej_dest_5", ej_dest, 5);
    chk("ej_payload_5c", ej_payload, 8'h5C);
    chk("ej_addr_err_0", ej_addr_err, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bad |= !link_rx_busy | !ej_valid;
      link_rx_data = (i == 3);
    end
    link_rx_data = 0;
    chk("ej_hold_busy", bad, 0);
    ack();
    chk("ej_valid_drop", ej_valid, 0);
    chk("ej_busy_drop", link_rx_busy, 0);
    repeat (3) @(negedge clk);
    chk("ej_no_restart", link_rx_busy, 0);

    // Address check: dest=7 flags, then dest=5 clears.
    send_frame({8'h77, 4'd7});
    chk("addr_err_dest7", ej_addr_err, 1);
    chk("addr_dest7", ej_dest, 7);
    ack();
    send_frame({8'h12, 4'd5});
    chk("addr_ok_dest5", ej_addr_err, 0);
    chk("addr_payload12", ej_payload, 8'h12);
    ack();

    // Reset during TX bit 6.
    inject(4'd1, 8'hF4);
    repeat (8) @(negedge clk);
    chk("tx_bit6_before_reset", link_tx_data, 1);
    reset = 0;
    @(negedge clk);
    chk("tx_reset_line", link_tx_data, 0);
    chk("tx_reset_ready", inj_ready, 1);
    reset = 1;
    repeat (2) @(negedge clk);

    // Reset during RX bit 4.
    @(negedge clk); link_rx_data = 1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); link_rx_data = (i % 2 == 0); end
    @(negedge clk);
    chk("rx_busy_before_reset", link_rx_busy, 1);
    reset = 0; link_rx_data = 0;
    @(negedge clk);
    chk("rx_reset_valid", ej_valid, 0);
    chk("rx_reset_busy", link_rx_busy, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    // Normal traffic after reset: simultaneous inject and eject, then more injects.
    fork
      inject(4'd2, 8'h11);
      send_frame(12'h5A5);
    join
    chk("post_rst_payload", ej_payload, 8'h5A);
    chk("post_rst_err", ej_addr_err, 0);
    ack();
    inject(4'd6, 8'h42);
    send_frame(12'h0F5);
    chk("post_rst_payload2", ej_payload, 8'h0F);
    ack();
    inject(4'd4, 8'h99);
    repeat (FW + 4) @(negedge clk);
    chk("final_tx_idle", inj_ready, 1);
`ifdef NI_STATS_EN
    chk("stats_inj_3", inj_count, 3);
    chk("stats_ej_2", ej_count, 2);
`endif

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
